// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame source.
// Holds the FSM state encoding and the idle line level.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAR
    } sfs_state_t;

    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_source.sv
// Parallel-to-serial frame source feeding the bit-serial sequence detector.
// Define SERIAL_FRAME_SOURCE_PARITY_EN to append an even-parity bit per frame.
module serial_frame_source
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam int OUT_POS = MSB_FIRST ? WIDTH - 1 : 0;

    sfs_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             last_data;
    logic             final_bit;
    logic             accept;

`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
    logic par_q, par_d;
`endif

    // The outgoing bit is always parked at the shift-out end of shreg.
    assign x_out   = shreg_q[OUT_POS];
    assign x_valid = valid_q;
    assign busy    = busy_q;

    assign last_data = (cnt_q == LAST_CNT);

`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
    assign final_bit = (state_q == ST_PAR);
`else
    assign final_bit = (state_q == ST_SHIFT) && last_data;
`endif

    assign frame_done = valid_q && shift_en && final_bit;
    assign load_ready = (state_q == ST_IDLE) || frame_done;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = data_in;
            cnt_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
            par_d   = ^data_in;
`endif
        end else if (shift_en) begin
            case (state_q)
                ST_SHIFT: begin
                    if (last_data) begin
`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
                        state_d          = ST_PAR;
                        shreg_d          = {WIDTH{IDLE_LEVEL}};
                        shreg_d[OUT_POS] = par_q;
`else
                        state_d = ST_IDLE;
                        shreg_d = {WIDTH{IDLE_LEVEL}};
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (MSB_FIRST)
                            shreg_d = shreg_q << 1;
                        else
                            shreg_d = shreg_q >> 1;
                    end
                end
                ST_PAR: begin
                    state_d = ST_IDLE;
                    shreg_d = {WIDTH{IDLE_LEVEL}};
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= {WIDTH{IDLE_LEVEL}};
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_serial_frame_source.sv
// Directed bench for serial_frame_source with a bit-level scoreboard.
// Follows SERIAL_FRAME_SOURCE_PARITY_EN when defined.
module tb_serial_frame_source;

`ifdef SERIAL_FRAME_SOURCE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int W  = 8;
    localparam int FL = W + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] m_data = '0;
    logic m_lv = 1'b0, m_sh = 1'b0;
    logic m_lr, m_x, m_xv, m_busy, m_fd;

    logic [W-1:0] l_data = '0;
    logic l_lv = 1'b0, l_sh = 1'b0;
    logic l_lr, l_x, l_xv, l_busy, l_fd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] qm[$];
    logic [1:0] ql[$];

    int m_falls_exp = 0, m_falls_obs = 0;
    logic m_prev_exp = 1'b0, m_prev_obs = 1'b0;
    int l_vcnt = 0, l_dcnt = 0;

    always #5 clk = ~clk;

    serial_frame_source #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_in(m_data),
        .load_valid(m_lv), .load_ready(m_lr), .shift_en(m_sh),
        .x_out(m_x), .x_valid(m_xv), .busy(m_busy),
        .frame_done(m_fd)
    );

    serial_frame_source #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(l_data),
        .load_valid(l_lv), .load_ready(l_lr), .shift_en(l_sh),
        .x_out(l_x), .x_valid(l_xv), .busy(l_busy),
        .frame_done(l_fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_m(input logic [W-1:0] w);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = w[W-1-i];
            qm.push_back({b, (i == W-1) && !PAR});
            if (m_prev_exp && !b) m_falls_exp++;
            m_prev_exp = b;
        end
        if (PAR) begin
            b = ^w;
            qm.push_back({b, 1'b1});
            if (m_prev_exp && !b) m_falls_exp++;
            m_prev_exp = b;
        end
    endtask

    task automatic push_l(input logic [W-1:0] w);
        for (int i = 0; i < W; i++)
            ql.push_back({w[i], (i == W-1) && !PAR});
        if (PAR) ql.push_back({^w, 1'b1});
    endtask

    task automatic load_m(input logic [W-1:0] w);
        bit ok = 1'b0;
        m_data = w;
        m_lv   = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (m_lr) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("m_load_accept", 32'(ok), 32'd1);
        if (ok) push_m(w);
        m_lv = 1'b0;
    endtask

    task automatic load_l(input logic [W-1:0] w);
        bit ok = 1'b0;
        l_data = w;
        l_lv   = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (l_lr) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("l_load_accept", 32'(ok), 32'd1);
        if (ok) push_l(w);
        l_lv = 1'b0;
    endtask

    task automatic drain_m();
        for (int i = 0; i < 200 && qm.size() != 0; i++)
            @(negedge clk);
        chk("m_drain", 32'(qm.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_l();
        for (int i = 0; i < 200 && ql.size() != 0; i++)
            @(negedge clk);
        chk("l_drain", 32'(ql.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a bit is consumed where x_valid && shift_en.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst) begin
            if (m_xv && m_sh) begin
                if (qm.size() == 0) begin
                    chk("m_extra_bit", 32'd1, 32'd0);
                end else begin
                    e = qm.pop_front();
                    chk("m_bit", 32'(m_x), 32'(e[1]));
                    chk("m_frame_done", 32'(m_fd), 32'(e[0]));
                    if (m_prev_obs && !m_x) m_falls_obs++;
                    m_prev_obs = m_x;
                end
            end else begin
                chk("m_done_quiet", 32'(m_fd), 32'd0);
            end
            if (!m_xv) chk("m_idle_level", 32'(m_x), 32'd0);
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst) begin
            if (l_xv) l_vcnt++;
            if (l_fd) l_dcnt++;
            if (l_xv && l_sh) begin
                if (ql.size() == 0) begin
                    chk("l_extra_bit", 32'd1, 32'd0);
                end else begin
                    e = ql.pop_front();
                    chk("l_bit", 32'(l_x), 32'(e[1]));
                    chk("l_frame_done", 32'(l_fd), 32'(e[0]));
                end
            end
            if (!l_xv) chk("l_idle_level", 32'(l_x), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic psh, px, pv;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_x_out", 32'(m_x), 32'd0);
        chk("rst_x_valid", 32'(m_xv), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_load_ready", 32'(m_lr), 32'd1);
        chk("rst_frame_done", 32'(m_fd), 32'd0);
        chk("rst_l_load_ready", 32'(l_lr), 32'd1);
        @(posedge clk);
        #1;

        // 1: A5 MSB first, continuous shift
        m_sh = 1'b1;
        load_m(8'hA5);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk("t1_valid", 32'(m_xv), 32'd1);
            chk("t1_busy", 32'(m_busy), 32'd1);
            if (i == FL - 1) begin
                chk("t1_last_ready", 32'(m_lr), 32'd1);
                chk("t1_last_done", 32'(m_fd), 32'd1);
            end else begin
                chk("t1_mid_ready", 32'(m_lr), 32'd0);
            end
        end
        @(negedge clk);
        chk("t1_after_valid", 32'(m_xv), 32'd0);
        chk("t1_after_x", 32'(m_x), 32'd0);
        chk("t1_after_busy", 32'(m_busy), 32'd0);
        chk("t1_q_empty", 32'(qm.size()), 32'd0);
        @(posedge clk);
        #1;

        // 2: LSB first, back-to-back 01 then 80
        l_sh = 1'b1;
        load_l(8'h01);
        load_l(8'h80);
        drain_l();
        repeat (2) @(posedge clk);
        #1;
        chk("t2_valid_cycles", 32'(l_vcnt), 32'(2 * FL));
        chk("t2_done_pulses", 32'(l_dcnt), 32'd2);

        // 3: C3 with shift_en toggling 1,0,0,1
        m_sh = 1'b1;
        load_m(8'hC3);
        pv = 1'b0; psh = 1'b1; px = 1'b0;
        for (int i = 0; i < 24; i++) begin
            m_sh = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk);
            if (pv && !psh) begin
                chk("t3_hold_x", 32'(m_x), 32'(px));
                chk("t3_hold_valid", 32'(m_xv), 32'd1);
            end
            pv = m_xv; psh = m_sh; px = m_x;
            @(posedge clk);
            #1;
        end
        m_sh = 1'b1;
        drain_m();

        // 4: reset while 4th bit of FF is on the line
        load_m(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_bit4_valid", 32'(m_xv), 32'd1);
        chk("t4_no_done", 32'(m_fd), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        qm.delete();
        @(negedge clk);
        chk("t4_x_out", 32'(m_x), 32'd0);
        chk("t4_x_valid", 32'(m_xv), 32'd0);
        chk("t4_busy", 32'(m_busy), 32'd0);
        chk("t4_load_ready", 32'(m_lr), 32'd1);
        @(posedge clk);
        #1;
        load_m(8'h0F);
        drain_m();

        // 5: 55 pulsed mid-frame of AA is ignored
        load_m(8'hAA);
        repeat (2) @(posedge clk);
        #1;
        m_data = 8'h55;
        m_lv   = 1'b1;
        @(negedge clk);
        chk("t5_busy_not_ready", 32'(m_lr), 32'd0);
        @(posedge clk);
        #1;
        m_lv   = 1'b0;
        m_data = '0;
        drain_m();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_55_frame", 32'(m_xv), 32'd0);
        end
        @(posedge clk);
        #1;

        // 6: parity frames and downstream 1->0 boundary count
        load_m(8'hA5);
        load_m(8'h07);
        drain_m();
        chk("t6_falls", 32'(m_falls_obs), 32'(m_falls_exp));
        chk("end_l_q", 32'(ql.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
